// File: rtl/llr_out_buffer.sv
// Saturating LLR collector with a two-frame ping-pong buffer, streamed out one LLR per cycle.
// Decouples the detector's fixed beat cadence from decoder back-pressure.
module llr_out_buffer #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 8,
    parameter int NSYM  = 8,
    parameter int NBIT  = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [2:0]       in_sym,
    input  logic [IN_W-1:0]  in_b1,
    input  logic [IN_W-1:0]  in_b2,
    input  logic [IN_W-1:0]  in_b3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_llr,
    output logic [4:0]       out_idx,
    output logic             out_last,
    output logic             frame_drop,
    output logic             seq_err,
    output logic             ovf_sticky
);

    localparam int         NLLR     = NSYM * NBIT;
    localparam logic [4:0] LAST_IDX = 5'(NLLR - 1);
    localparam logic [2:0] LAST_SYM = 3'(NSYM - 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_e;

    wstate_e                            state_q;
    logic [2:0]                         exp_sym_q;
    logic                               wr_bank_q, rd_bank_q;
    logic [1:0]                         full_q, full_d;
    logic [4:0]                         rd_idx_q, rd_idx_d;
    logic [1:0][NLLR-1:0][OUT_W-1:0]    bank_q;
    logic                               frame_drop_q, seq_err_q, ovf_q;

    logic [NBIT-1:0][IN_W-1:0] beat;
    logic [4:0]                wr_base;
    logic                      in_seq, write_beat, wr_done, rd_fire, rd_release;

    // Keep the low OUT_W bits when the dropped upper bits are pure sign extension.
    function automatic logic [OUT_W-1:0] sat(input logic [IN_W-1:0] v);
        logic [IN_W-OUT_W:0] hi;
        hi = v[IN_W-1:OUT_W-1];
        if ((&hi) || !(|hi))
            return v[OUT_W-1:0];
        return v[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    endfunction

    assign beat    = {in_b3, in_b2, in_b1};
    assign wr_base = 5'(in_sym) * 5'(NBIT);

    // A sym-0 beat opens a frame whenever the target bank is free; mid-fill the bank is never full.
    assign in_seq     = (state_q == W_FILL) && (in_sym == exp_sym_q);
    assign write_beat = in_valid && (in_seq || ((in_sym == 3'd0) && !full_q[wr_bank_q]));
    assign wr_done    = in_valid && in_seq && (in_sym == LAST_SYM);

    assign rd_fire    = full_q[rd_bank_q] && out_ready;
    assign rd_release = rd_fire && (rd_idx_q == LAST_IDX);

    always_comb begin
        full_d   = full_q;
        rd_idx_d = rd_idx_q;
        if (rd_fire)
            rd_idx_d = rd_release ? 5'd0 : rd_idx_q + 5'd1;
        if (rd_release)
            full_d[rd_bank_q] = 1'b0;
        if (wr_done)
            full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full_q    <= '0;
            rd_idx_q  <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            full_q   <= full_d;
            rd_idx_q <= rd_idx_d;
            if (rd_release)
                rd_bank_q <= ~rd_bank_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= W_IDLE;
            exp_sym_q    <= '0;
            wr_bank_q    <= 1'b0;
            bank_q       <= '0;
            frame_drop_q <= 1'b0;
            seq_err_q    <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            frame_drop_q <= 1'b0;
            seq_err_q    <= 1'b0;
            if (write_beat)
                for (int k = 0; k < NBIT; k++)
                    bank_q[wr_bank_q][wr_base + 5'(k)] <= sat(beat[k]);
            if (in_valid) begin
                case (state_q)
                    W_IDLE, W_DROP: begin
                        if (in_sym == 3'd0) begin
                            if (state_q == W_DROP)
                                seq_err_q <= 1'b1;
                            if (full_q[wr_bank_q]) begin
                                frame_drop_q <= 1'b1;
                                ovf_q        <= 1'b1;
                                state_q      <= W_DROP;
                            end else begin
                                exp_sym_q <= 3'd1;
                                state_q   <= W_FILL;
                            end
                        end else if (state_q == W_DROP) begin
                            if (in_sym == LAST_SYM)
                                state_q <= W_IDLE;
                        end else begin
                            seq_err_q <= 1'b1;
                        end
                    end
                    W_FILL: begin
                        if (in_seq) begin
                            exp_sym_q <= exp_sym_q + 3'd1;
                            if (in_sym == LAST_SYM) begin
                                wr_bank_q <= ~wr_bank_q;
                                state_q   <= W_IDLE;
                            end
                        end else begin
                            seq_err_q <= 1'b1;
                            if (in_sym == 3'd0)
                                exp_sym_q <= 3'd1;
                            else
                                state_q <= W_IDLE;
                        end
                    end
                    default: state_q <= W_IDLE;
                endcase
            end
        end
    end

    assign out_valid  = full_q[rd_bank_q];
    assign out_llr    = bank_q[rd_bank_q][rd_idx_q];
    assign out_idx    = rd_idx_q;
    assign out_last   = (rd_idx_q == LAST_IDX);
    assign frame_drop = frame_drop_q;
    assign seq_err    = seq_err_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_llr_out_buffer.sv
// Directed bench for llr_out_buffer: streaming, saturation, overflow drop, sequence errors,
// stall stability and asynchronous reset mid-readout.
module tb_llr_out_buffer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_sym = '0;
    logic [8:0] in_b1 = '0, in_b2 = '0, in_b3 = '0;
    logic       out_ready = 1'b0;
    logic       out_valid, out_last, frame_drop, seq_err, ovf_sticky;
    logic [7:0] out_llr;
    logic [4:0] out_idx;

    int total = 0;
    int bad   = 0;

    llr_out_buffer dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_sym    (in_sym),
        .in_b1     (in_b1),
        .in_b2     (in_b2),
        .in_b3     (in_b3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_llr   (out_llr),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .frame_drop(frame_drop),
        .seq_err   (seq_err),
        .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int s, input int v1, input int v2, input int v3);
        in_valid = 1'b1;
        in_sym   = 3'(s);
        in_b1    = 9'(v1);
        in_b2    = 9'(v2);
        in_b3    = 9'(v3);
        step();
        in_valid = 1'b0;
    endtask

    task automatic frame(input int base);
        for (int s = 0; s < 8; s++)
            beat(s, base + 3*s, base + 3*s + 1, base + 3*s + 2);
    endtask

    // Expects out_ready=1 and a full frame at the head of the read side.
    task automatic drain(input int base);
        for (int i = 0; i < 24; i++) begin
            chk("drain_vld", 32'(out_valid), 32'd1);
            chk("drain_idx", 32'(out_idx), 32'(i));
            chk("drain_llr", 32'(out_llr), 32'(base + i));
            chk("drain_last", 32'(out_last), 32'(i == 23));
            step();
        end
    endtask

    initial begin
        int         e;
        int         cyc;
        logic [15:0] pat;

        // reset values
        #12;
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_llr", 32'(out_llr), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_drop", 32'(frame_drop), 32'd0);
        chk("rst_seq", 32'(seq_err), 32'd0);
        chk("rst_ovf", 32'(ovf_sticky), 32'd0);
        rstn = 1'b1;
        step();

        // single frame, out_llr == out_idx, valid one cycle after sym 7
        out_ready = 1'b1;
        for (int s = 0; s < 7; s++)
            beat(s, 3*s, 3*s + 1, 3*s + 2);
        chk("s1_vld_pre", 32'(out_valid), 32'd0);
        beat(7, 21, 22, 23);
        drain(0);
        chk("s1_vld_post", 32'(out_valid), 32'd0);

        // saturation on sym 0, with a one-cycle stall at the head
        out_ready = 1'b0;
        beat(0, 'h0FF, 'h100, 'h1F6);
        for (int s = 1; s < 8; s++)
            beat(s, 3*s, 3*s + 1, 3*s + 2);
        chk("sat_vld", 32'(out_valid), 32'd1);
        chk("sat_pos", 32'(out_llr), 32'h7F);
        step();
        chk("sat_hold", 32'(out_llr), 32'h7F);
        chk("sat_hold_idx", 32'(out_idx), 32'd0);
        out_ready = 1'b1;
        step();
        chk("sat_neg", 32'(out_llr), 32'h80);
        step();
        chk("sat_small", 32'(out_llr), 32'hF6);
        step();
        for (int i = 3; i < 24; i++) begin
            chk("sat_idx", 32'(out_idx), 32'(i));
            chk("sat_llr", 32'(out_llr), 32'(i));
            step();
        end
        chk("sat_vld_post", 32'(out_valid), 32'd0);

        // back-pressure: two frames buffered, third dropped
        out_ready = 1'b0;
        frame(40);
        frame(64);
        beat(0, 100, 101, 102);
        chk("bp_drop", 32'(frame_drop), 32'd1);
        chk("bp_ovf", 32'(ovf_sticky), 32'd1);
        chk("bp_seq", 32'(seq_err), 32'd0);
        beat(1, 103, 104, 105);
        chk("bp_drop_pulse", 32'(frame_drop), 32'd0);
        for (int s = 2; s < 8; s++)
            beat(s, 100 + 3*s, 101 + 3*s, 102 + 3*s);
        chk("bp_drop_end", 32'(frame_drop), 32'd0);
        out_ready = 1'b1;
        drain(40);
        drain(64);
        chk("bp_vld_post", 32'(out_valid), 32'd0);
        chk("bp_ovf_keep", 32'(ovf_sticky), 32'd1);

        // sequence errors: skip in fill, stray beat in idle, sym-0 restart in fill
        beat(0, 1, 1, 1);
        beat(1, 1, 1, 1);
        chk("seq_ok", 32'(seq_err), 32'd0);
        beat(3, 1, 1, 1);
        chk("seq_skip", 32'(seq_err), 32'd1);
        chk("seq_novld", 32'(out_valid), 32'd0);
        beat(5, 1, 1, 1);
        chk("seq_idle", 32'(seq_err), 32'd1);
        beat(0, 2, 2, 2);
        chk("seq_start", 32'(seq_err), 32'd0);
        beat(1, 2, 2, 2);
        beat(0, 90, 91, 92);
        chk("seq_restart", 32'(seq_err), 32'd1);
        for (int s = 1; s < 7; s++)
            beat(s, 90 + 3*s, 91 + 3*s, 92 + 3*s);
        chk("seq_vld_pre", 32'(out_valid), 32'd0);
        beat(7, 111, 112, 113);
        drain(90);

        // stall stability under an irregular ready pattern
        out_ready = 1'b0;
        frame(20);
        e   = 0;
        cyc = 0;
        pat = 16'hB274;
        while (e < 24 && cyc < 200) begin
            out_ready = pat[cyc % 16];
            chk("stall_vld", 32'(out_valid), 32'd1);
            chk("stall_idx", 32'(out_idx), 32'(e));
            chk("stall_llr", 32'(out_llr), 32'(20 + e));
            step();
            if (out_ready)
                e++;
            cyc++;
        end
        chk("stall_count", 32'(e), 32'd24);
        out_ready = 1'b0;
        chk("stall_vld_post", 32'(out_valid), 32'd0);

        // asynchronous reset in the middle of a readout
        frame(0);
        out_ready = 1'b1;
        repeat (10) step();
        chk("rr_idx10", 32'(out_idx), 32'd10);
        out_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("rr_vld", 32'(out_valid), 32'd0);
        chk("rr_idx", 32'(out_idx), 32'd0);
        chk("rr_ovf", 32'(ovf_sticky), 32'd0);
        chk("rr_llr", 32'(out_llr), 32'd0);
        #1 rstn = 1'b1;
        step();
        out_ready = 1'b1;
        frame(30);
        drain(30);
        chk("rr_vld_post", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
